// File: rtl/rv_ex_stage_if.sv
// Bus bundle between the RV32I execute stage and its neighbours (ID, hazard unit,
// ALU, forward sources and the EX/MEM consumer).
interface rv_ex_stage_if;
  logic        i_stall;
  logic        i_flush;
  logic        i_id_valid;
  logic [31:0] i_id_pc;
  logic [31:0] i_id_rs1_data;
  logic [31:0] i_id_rs2_data;
  logic [31:0] i_id_imm;
  logic [4:0]  i_id_rs1_idx;
  logic [4:0]  i_id_rs2_idx;
  logic [4:0]  i_id_rd_idx;
  logic [4:0]  i_id_alu_ctrl;
  logic        i_id_src_a_pc;
  logic        i_id_src_b_imm;
  logic        i_id_branch;
  logic        i_id_jal;
  logic        i_id_jalr;
  logic        i_id_mem_re;
  logic        i_id_mem_we;
  logic        i_id_rd_we;
  logic        i_mem_fwd_we;
  logic [4:0]  i_mem_fwd_idx;
  logic [31:0] i_mem_fwd_data;
  logic        i_wb_fwd_we;
  logic [4:0]  i_wb_fwd_idx;
  logic [31:0] i_wb_fwd_data;
  logic [31:0] o_alu_src_a;
  logic [31:0] o_alu_src_b;
  logic [4:0]  o_alu_ctrl;
  logic [31:0] i_alu_result;
  logic        i_alu_zero;
  logic        o_redirect;
  logic [31:0] o_redirect_pc;
  logic        o_load_use;
  logic        o_mem_valid;
  logic [31:0] o_mem_result;
  logic [31:0] o_mem_store_data;
  logic [4:0]  o_mem_rd_idx;
  logic        o_mem_rd_we;
  logic        o_mem_re;
  logic        o_mem_we;

  modport slave (
    input  i_stall, i_flush, i_id_valid, i_id_pc, i_id_rs1_data, i_id_rs2_data,
           i_id_imm, i_id_rs1_idx, i_id_rs2_idx, i_id_rd_idx, i_id_alu_ctrl,
           i_id_src_a_pc, i_id_src_b_imm, i_id_branch, i_id_jal, i_id_jalr,
           i_id_mem_re, i_id_mem_we, i_id_rd_we,
           i_mem_fwd_we, i_mem_fwd_idx, i_mem_fwd_data,
           i_wb_fwd_we, i_wb_fwd_idx, i_wb_fwd_data,
           i_alu_result, i_alu_zero,
    output o_alu_src_a, o_alu_src_b, o_alu_ctrl, o_redirect, o_redirect_pc,
           o_load_use, o_mem_valid, o_mem_result, o_mem_store_data,
           o_mem_rd_idx, o_mem_rd_we, o_mem_re, o_mem_we
  );

  modport master (
    output i_stall, i_flush, i_id_valid, i_id_pc, i_id_rs1_data, i_id_rs2_data,
           i_id_imm, i_id_rs1_idx, i_id_rs2_idx, i_id_rd_idx, i_id_alu_ctrl,
           i_id_src_a_pc, i_id_src_b_imm, i_id_branch, i_id_jal, i_id_jalr,
           i_id_mem_re, i_id_mem_we, i_id_rd_we,
           i_mem_fwd_we, i_mem_fwd_idx, i_mem_fwd_data,
           i_wb_fwd_we, i_wb_fwd_idx, i_wb_fwd_data,
           i_alu_result, i_alu_zero,
    input  o_alu_src_a, o_alu_src_b, o_alu_ctrl, o_redirect, o_redirect_pc,
           o_load_use, o_mem_valid, o_mem_result, o_mem_store_data,
           o_mem_rd_idx, o_mem_rd_we, o_mem_re, o_mem_we
  );
endinterface

// File: rtl/rv_ex_stage.sv
// RV32I execute stage: EX register, operand forwarding, branch/jump resolution and
// the EX/MEM register. Define RV_EX_FWD_EN to enable MEM/WB operand forwarding.
module rv_ex_stage (
  input logic      i_clk,
  input logic      i_reset_n,
  rv_ex_stage_if.slave bus
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic [4:0]  rd_idx;
    logic [4:0]  alu_ctrl;
    logic        src_a_pc;
    logic        src_b_imm;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic        mem_re;
    logic        mem_we;
    logic        rd_we;
  } ex_t;

  ex_t         ex_q, ex_d;
  logic        redirect_done_q, redirect_done_d;
  logic        mem_valid_q, mem_valid_d;
  logic [31:0] mem_result_q, mem_result_d;
  logic [31:0] mem_store_q, mem_store_d;
  logic [4:0]  mem_rd_idx_q, mem_rd_idx_d;
  logic        mem_rd_we_q, mem_rd_we_d;
  logic        mem_re_q, mem_re_d;
  logic        mem_we_q, mem_we_d;

  logic [31:0] fwd_rs1, fwd_rs2;
  logic        taken;
  logic [31:0] target;

  // A flush loads a full bubble so no stale control bits survive into EX.
  always_comb begin
    ex_d = ex_q;
    if (bus.i_flush) begin
      ex_d = '0;
    end else begin
      ex_d.valid     = bus.i_id_valid;
      ex_d.pc        = bus.i_id_pc;
      ex_d.rs1_data  = bus.i_id_rs1_data;
      ex_d.rs2_data  = bus.i_id_rs2_data;
      ex_d.imm       = bus.i_id_imm;
      ex_d.rs1_idx   = bus.i_id_rs1_idx;
      ex_d.rs2_idx   = bus.i_id_rs2_idx;
      ex_d.rd_idx    = bus.i_id_rd_idx;
      ex_d.alu_ctrl  = bus.i_id_alu_ctrl;
      ex_d.src_a_pc  = bus.i_id_src_a_pc;
      ex_d.src_b_imm = bus.i_id_src_b_imm;
      ex_d.branch    = bus.i_id_branch;
      ex_d.jal       = bus.i_id_jal;
      ex_d.jalr      = bus.i_id_jalr;
      ex_d.mem_re    = bus.i_id_mem_re;
      ex_d.mem_we    = bus.i_id_mem_we;
      ex_d.rd_we     = bus.i_id_rd_we;
    end
  end

`ifdef RV_EX_FWD_EN
  function automatic logic [31:0] fwdSel(
    input logic [4:0]  idx,
    input logic [31:0] latched,
    input logic        mem_we,
    input logic [4:0]  mem_idx,
    input logic [31:0] mem_data,
    input logic        wb_we,
    input logic [4:0]  wb_idx,
    input logic [31:0] wb_data
  );
    logic [31:0] val;
    val = latched;
    if (idx != 5'd0) begin
      if (mem_we && mem_idx == idx)     val = mem_data;
      else if (wb_we && wb_idx == idx)  val = wb_data;
    end
    return val;
  endfunction

  always_comb begin
    fwd_rs1 = fwdSel(ex_q.rs1_idx, ex_q.rs1_data, bus.i_mem_fwd_we, bus.i_mem_fwd_idx,
                     bus.i_mem_fwd_data, bus.i_wb_fwd_we, bus.i_wb_fwd_idx, bus.i_wb_fwd_data);
    fwd_rs2 = fwdSel(ex_q.rs2_idx, ex_q.rs2_data, bus.i_mem_fwd_we, bus.i_mem_fwd_idx,
                     bus.i_mem_fwd_data, bus.i_wb_fwd_we, bus.i_wb_fwd_idx, bus.i_wb_fwd_data);
  end

  assign bus.o_load_use = ex_q.valid && ex_q.mem_re && (ex_q.rd_idx != 5'd0) &&
                          bus.i_id_valid &&
                          ((ex_q.rd_idx == bus.i_id_rs1_idx) || (ex_q.rd_idx == bus.i_id_rs2_idx));
`else
  assign fwd_rs1 = ex_q.rs1_data;
  assign fwd_rs2 = ex_q.rs2_data;

  // Without forwarding any pending write in EX or MEM is a hazard for ID.
  function automatic logic rawHit(
    input logic [4:0] idx,
    input logic       ex_hit_en,
    input logic [4:0] ex_rd,
    input logic       mem_we,
    input logic [4:0] mem_idx
  );
    return (idx != 5'd0) &&
           ((ex_hit_en && ex_rd == idx) || (mem_we && mem_idx == idx));
  endfunction

  assign bus.o_load_use = bus.i_id_valid &&
    (rawHit(bus.i_id_rs1_idx, ex_q.valid && ex_q.rd_we, ex_q.rd_idx,
            bus.i_mem_fwd_we, bus.i_mem_fwd_idx) ||
     rawHit(bus.i_id_rs2_idx, ex_q.valid && ex_q.rd_we, ex_q.rd_idx,
            bus.i_mem_fwd_we, bus.i_mem_fwd_idx));
`endif

  assign bus.o_alu_src_a = ex_q.src_a_pc  ? ex_q.pc  : fwd_rs1;
  assign bus.o_alu_src_b = ex_q.src_b_imm ? ex_q.imm : fwd_rs2;
  assign bus.o_alu_ctrl  = ex_q.alu_ctrl;

  assign taken  = ex_q.valid && ((ex_q.branch && !bus.i_alu_zero) || ex_q.jal || ex_q.jalr);
  assign target = ex_q.jalr ? ((fwd_rs1 + ex_q.imm) & 32'hFFFF_FFFE) : (ex_q.pc + ex_q.imm);

  assign bus.o_redirect    = taken && !redirect_done_q;
  assign bus.o_redirect_pc = target;

  // Remember a redirect already issued while EX is frozen so it fires only once.
  always_comb begin
    redirect_done_d = redirect_done_q;
    if (bus.i_stall) begin
      if (bus.o_redirect) redirect_done_d = 1'b1;
    end else begin
      redirect_done_d = 1'b0;
    end
  end

  always_comb begin
    mem_valid_d  = ex_q.valid;
    mem_result_d = (ex_q.jal || ex_q.jalr) ? (ex_q.pc + 32'd4) : bus.i_alu_result;
    mem_store_d  = fwd_rs2;
    mem_rd_idx_d = ex_q.rd_idx;
    mem_rd_we_d  = ex_q.valid && ex_q.rd_we;
    mem_re_d     = ex_q.valid && ex_q.mem_re;
    mem_we_d     = ex_q.valid && ex_q.mem_we;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      ex_q            <= '0;
      redirect_done_q <= 1'b0;
      mem_valid_q     <= 1'b0;
      mem_result_q    <= '0;
      mem_store_q     <= '0;
      mem_rd_idx_q    <= '0;
      mem_rd_we_q     <= 1'b0;
      mem_re_q        <= 1'b0;
      mem_we_q        <= 1'b0;
    end else begin
      redirect_done_q <= redirect_done_d;
      if (!bus.i_stall) begin
        ex_q         <= ex_d;
        mem_valid_q  <= mem_valid_d;
        mem_result_q <= mem_result_d;
        mem_store_q  <= mem_store_d;
        mem_rd_idx_q <= mem_rd_idx_d;
        mem_rd_we_q  <= mem_rd_we_d;
        mem_re_q     <= mem_re_d;
        mem_we_q     <= mem_we_d;
      end
    end
  end

  assign bus.o_mem_valid      = mem_valid_q;
  assign bus.o_mem_result     = mem_result_q;
  assign bus.o_mem_store_data = mem_store_q;
  assign bus.o_mem_rd_idx     = mem_rd_idx_q;
  assign bus.o_mem_rd_we      = mem_rd_we_q;
  assign bus.o_mem_re         = mem_re_q;
  assign bus.o_mem_we         = mem_we_q;

endmodule
